keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_bounce_gen.sv | 85 ++++++++
 rtl/keypad_emulator.sv | 133 +++++++++++++
 tb/tb_keypad_emulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared keypad definitions: matrix geometry, FSM encoding and
//               default contact-bounce timing for emulator and scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int c_num_keys = 16;
    localparam int c_num_cols = 4;
    localparam int c_num_rows = 4;
    localparam int c_key_w    = 4;
    localparam int c_col_w    = 2;
    localparam int c_row_w    = 2;
    localparam int c_hold_w   = 16;

    localparam int c_bounce_cycles_default = 8;
    localparam int c_bounce_period_default = 2;

    localparam logic [1:0] c_st_idle           = 2'd0;
    localparam logic [1:0] c_st_bounce_press   = 2'd1;
    localparam logic [1:0] c_st_hold           = 2'd2;
    localparam logic [1:0] c_st_bounce_release = 2'd3;

    // Key index is column in the upper bits, row in the lower bits.
    function automatic logic [c_key_w-1:0] key_idx(input logic [c_col_w-1:0] c,
                                                   input logic [c_row_w-1:0] r);
        return {c, r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : keypad_bounce_gen
// Description : Contact-bounce window generator: counts BOUNCE_CYCLES cycles
//               after start and toggles the contact every BOUNCE_PERIOD.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_bounce_gen
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = c_bounce_cycles_default,
    parameter int BOUNCE_PERIOD = c_bounce_period_default
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic polarity,
    output logic level,
    output logic done
);

    if (BOUNCE_CYCLES == 0) begin : g_no_bounce
        logic w_unused;
        assign w_unused = ^{clk, rst, start, polarity};
        assign level    = 1'b0;
        assign done     = 1'b1;
    end else begin : g_bounce
        localparam int c_cnt_w = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
        localparam int c_ph_w  = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
        localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BOUNCE_CYCLES - 1);
        localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(BOUNCE_PERIOD - 1);

        logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
        logic [c_ph_w-1:0]  r_ph_cnt, w_ph_cnt_nxt;
        logic               r_phase, w_phase_nxt;
        logic               r_running, w_running_nxt;
        logic               w_last;

        assign w_last = r_running && (r_cnt == c_cnt_last);

        always_comb begin
            w_cnt_nxt     = r_cnt;
            w_ph_cnt_nxt  = r_ph_cnt;
            w_phase_nxt   = r_phase;
            w_running_nxt = r_running;
            if (start) begin
                w_cnt_nxt     = '0;
                w_ph_cnt_nxt  = '0;
                w_phase_nxt   = 1'b0;
                w_running_nxt = 1'b1;
            end else if (w_last) begin
                w_running_nxt = 1'b0;
            end else if (r_running) begin
                w_cnt_nxt = r_cnt + c_cnt_w'(1);
                if (r_ph_cnt == c_ph_last) begin
                    w_ph_cnt_nxt = '0;
                    w_phase_nxt  = ~r_phase;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + c_ph_w'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt     <= '0;
                r_ph_cnt  <= '0;
                r_phase   <= 1'b0;
                r_running <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_ph_cnt  <= w_ph_cnt_nxt;
                r_phase   <= w_phase_nxt;
                r_running <= w_running_nxt;
            end
        end

        // Level is for the counter value about to be registered, so the caller
        // can register it alongside its own state.
        assign level = w_phase_nxt ^ ~polarity;
        assign done  = w_last;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : 4x4 matrix keypad model: replays bounced key presses on
//               command and answers column strobes with row sense lines.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = c_bounce_cycles_default,
    parameter int BOUNCE_PERIOD = c_bounce_period_default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [c_key_w-1:0]    cmd_key,
    input  logic [c_hold_w-1:0]   cmd_hold,
    input  logic [c_num_keys-1:0] force_mask,
    input  logic [c_num_cols-1:0] col,
    output logic [c_num_rows-1:0] row,
    output logic [c_num_keys-1:0] pressed,
    output logic                  busy
);

    logic [1:0]            r_state, w_state_nxt;
    logic [c_key_w-1:0]    r_key, w_key_nxt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_num_keys-1:0] r_pressed, w_pressed_nxt;
    logic [c_num_rows-1:0] r_row, w_row_nxt;
    logic                  w_accept;
    logic                  w_hold_last;
    logic                  w_bounce_start;
    logic                  w_bounce_pol;
    logic                  w_bounce_level;
    logic                  w_bounce_done;
    logic                  w_active_nxt;

    assign cmd_ready   = (r_state == c_st_idle);
    assign busy        = ~cmd_ready;
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_hold_last = (r_hold_cnt == '0);
    assign w_key_nxt   = w_accept ? cmd_key : r_key;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept)
                    w_state_nxt = (BOUNCE_CYCLES == 0) ? c_st_hold : c_st_bounce_press;
            end
            c_st_bounce_press: begin
                if (w_bounce_done)
                    w_state_nxt = c_st_hold;
            end
            c_st_hold: begin
                if (w_hold_last)
                    w_state_nxt = (BOUNCE_CYCLES == 0) ? c_st_idle : c_st_bounce_release;
            end
            c_st_bounce_release: begin
                if (w_bounce_done)
                    w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_bounce_pol   = (w_state_nxt == c_st_bounce_release);
    assign w_bounce_start = (w_state_nxt != r_state) &&
                            ((w_state_nxt == c_st_bounce_press) || w_bounce_pol);

    keypad_bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BOUNCE_PERIOD (BOUNCE_PERIOD)
    ) u_bounce (
        .clk      (clk),
        .rst      (rst),
        .start    (w_bounce_start),
        .polarity (w_bounce_pol),
        .level    (w_bounce_level),
        .done     (w_bounce_done)
    );

    // Contact state is computed for the upcoming state so pressed lines up
    // with the state register.
    always_comb begin
        w_active_nxt = 1'b0;
        case (w_state_nxt)
            c_st_hold:           w_active_nxt = 1'b1;
            c_st_bounce_press,
            c_st_bounce_release: w_active_nxt = w_bounce_level;
            default:             w_active_nxt = 1'b0;
        endcase
    end

    assign w_pressed_nxt = force_mask |
                           (w_active_nxt ? (c_num_keys'(1) << w_key_nxt) : '0);

    for (genvar gr = 0; gr < c_num_rows; gr++) begin : g_row
        logic [c_num_cols-1:0] w_hits;
        for (genvar gc = 0; gc < c_num_cols; gc++) begin : g_col
            assign w_hits[gc] = ~col[c_num_cols-1-gc] &
                                r_pressed[key_idx(c_col_w'(gc), c_row_w'(gr))];
        end
        assign w_row_nxt[c_num_rows-1-gr] = ~|w_hits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_key      <= '0;
            r_hold_cnt <= '0;
            r_pressed  <= '0;
            r_row      <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_pressed <= w_pressed_nxt;
            r_row     <= w_row_nxt;
            if (w_accept) begin
                r_key      <= cmd_key;
                r_hold_cnt <= (cmd_hold == '0) ? '0 : cmd_hold - c_hold_w'(1);
            end else if ((r_state == c_st_hold) && !w_hold_last) begin
                r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
            end
        end
    end

    assign pressed = r_pressed;
    assign row     = r_row;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Scoreboard bench for keypad_emulator, one instance with bounce
//               (8/2) and one without (0), driven by shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic [3:0]  cmd_key    = 4'h0;
    logic [15:0] cmd_hold   = 16'h0;
    logic [15:0] force_mask = 16'h0;
    logic [3:0]  col        = 4'hF;

    logic [1:0]       cmd_ready;
    logic [1:0]       busy;
    logic [1:0][3:0]  row;
    logic [1:0][15:0] pressed;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(8), .BOUNCE_PERIOD(2)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .force_mask(force_mask),
        .col(col), .row(row[0]), .pressed(pressed[0]), .busy(busy[0])
    );

    keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1)) dut_n (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .force_mask(force_mask),
        .col(col), .row(row[1]), .pressed(pressed[1]), .busy(busy[1])
    );

    typedef struct packed {
        logic [1:0][15:0] pressed;
        logic [1:0][3:0]  row;
        logic [1:0]       ready;
    } exp_t;

    typedef struct packed {
        logic [15:0] got;
        logic [15:0] want;
    } scan_t;

    exp_t  sb_q[$];
    scan_t scan_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic int bc_of(input int g);
        return (g == 0) ? 8 : 0;
    endfunction

    function automatic int bp_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    // Contact of the commanded key at cycle pos of a command's busy window.
    function automatic bit active_closed(input int pos, input int bc, input int bp, input int hold);
        if (pos < bc)
            return ((pos / bp) % 2) == 0;
        if (pos < bc + hold)
            return 1'b1;
        return (((pos - bc - hold) / bp) % 2) == 1;
    endfunction

    function automatic logic [3:0] row_of(input logic [3:0] c, input logic [15:0] p);
        logic [3:0] r = 4'hF;
        for (int k = 0; k < 16; k++)
            if (p[4'(k)] && !c[2'(3 - k / 4)])
                r[2'(3 - k % 4)] = 1'b0;
        return r;
    endfunction

    // Reference model: one busy window per accepted command.
    bit          m_busy[2];
    int          m_pos[2];
    int          m_hold[2];
    logic [3:0]  m_key[2];
    logic [15:0] m_pressed[2];
    logic [3:0]  m_row[2];
    exp_t        m_exp;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_busy[g]    = 1'b0;
                m_pressed[g] = 16'h0;
                m_row[g]     = 4'hF;
            end else begin
                m_row[g] = row_of(col, m_pressed[g]);
                if (m_busy[g]) begin
                    m_pos[g]++;
                    if (m_pos[g] == 2 * bc_of(g) + m_hold[g])
                        m_busy[g] = 1'b0;
                end else if (cmd_valid) begin
                    m_busy[g] = 1'b1;
                    m_pos[g]  = 0;
                    m_key[g]  = cmd_key;
                    m_hold[g] = (cmd_hold == 16'h0) ? 1 : int'(cmd_hold);
                end
                m_pressed[g] = force_mask;
                if (m_busy[g] && active_closed(m_pos[g], bc_of(g), bp_of(g), m_hold[g]))
                    m_pressed[g][m_key[g]] = 1'b1;
            end
            m_exp.pressed[1'(g)] = m_pressed[g];
            m_exp.row[1'(g)]     = m_row[g];
            m_exp.ready[1'(g)]   = !m_busy[g];
        end
        sb_q.push_back(m_exp);
    end

    task automatic check(input string name, input int g, input logic [15:0] got,
                         input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s dut%0d: got 0x%h, expected 0x%h", name, g, got, want);
        end
    endtask

    exp_t  mon_e;
    scan_t mon_s;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            for (int g = 0; g < 2; g++) begin
                check("pressed", g, pressed[1'(g)], mon_e.pressed[1'(g)]);
                check("row", g, {12'h0, row[1'(g)]}, {12'h0, mon_e.row[1'(g)]});
                check("cmd_ready", g, {15'h0, cmd_ready[1'(g)]}, {15'h0, mon_e.ready[1'(g)]});
                check("busy", g, {15'h0, busy[1'(g)]}, {15'h0, ~mon_e.ready[1'(g)]});
            end
        end
        if (scan_q.size() > 0) begin
            mon_s = scan_q.pop_front();
            check("scan_keys", 0, mon_s.got, mon_s.want);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Simple column-walking scanner on the bounced instance.
    task automatic scan_keys(input logic [15:0] want);
        logic [15:0] keys = 16'h0;
        for (int c = 0; c < 4; c++) begin
            col = 4'hF;
            col[2'(3 - c)] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            for (int r = 0; r < 4; r++)
                if (!row[0][2'(3 - r)])
                    keys[4'(4 * c + r)] = 1'b1;
            @(posedge clk);
            #1;
        end
        col = 4'hF;
        scan_q.push_back('{got: keys, want: want});
    endtask

    initial begin
        tick(3);
        rst = 1'b0;

        cmd_key = 4'd5; cmd_hold = 16'd10; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        tick(30);

        force_mask = 16'h0021;
        col = 4'b0111; tick(2);
        col = 4'b1011; tick(2);
        col = 4'b0011; tick(2);
        col = 4'b1111; tick(2);
        force_mask = 16'h0;

        cmd_hold = 16'd0; cmd_valid = 1'b1; cmd_key = 4'd3;
        tick(2);
        cmd_key = 4'd12;
        tick(2);
        cmd_valid = 1'b0;
        tick(25);

        cmd_key = 4'd9; cmd_hold = 16'd20; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        cmd_key = 4'd2; cmd_hold = 16'd3; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        tick(30);

        cmd_key = 4'd10; cmd_hold = 16'd200; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        tick(12);
        scan_keys(16'h0400);
        tick(250);
        scan_keys(16'h0000);

        repeat (3000) begin
            rst       = ($urandom_range(0, 499) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_key   = 4'($urandom);
            cmd_hold  = 16'($urandom_range(0, 12));
            col       = 4'($urandom);
            if ($urandom_range(0, 39) == 0)
                force_mask = 16'($urandom & $urandom & $urandom);
            tick(1);
        end

        rst = 1'b0;
        cmd_valid = 1'b0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
